apb_master_arbiter: RTL and testbench



---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/apb_rr_arbiter.sv | 38 +++
 rtl/apb_master_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB master arbiter.
// Holds the APB phase encoding (it matches the slave's state encoding) and the
// default address/data widths of the shared 32x8 slave memory.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } apb_state_e;

    localparam int unsigned DefAw = 5;
    localparam int unsigned DefDw = 8;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational rotating-priority picker.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index that currently has the highest priority
//   gnt_o  - one-hot grant (all zero when nothing is requested)
//   idx_o  - binary index of the granted requester
//   any_o  - at least one request present
module apb_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr_i, wrapping at NREQ; first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_i) + i) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master that shares one APB slave between NREQ local requesters.
// Requests are granted round-robin and run through SETUP/ACCESS; read data
// and error status come back to the granted requester. All outputs registered.
// Ports:
//   CLK, Rst                   - clock, asynchronous active-high reset
//   req_valid/write/addr/wdata - per-requester request (addr/wdata packed)
//   req_ready                  - one-hot accept pulse (during SETUP)
//   rsp_valid                  - one-hot completion pulse
//   rsp_rdata, rsp_err         - result of the last completion, held
//   PSEL..PWDATA               - APB master outputs
//   PREADY, PRDATA, PSLVERR    - APB slave response
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [AW-1:0]    PADDR,
    output logic [DW-1:0]    PWDATA,
    input  logic             PREADY,
    input  logic [DW-1:0]    PRDATA,
    input  logic             PSLVERR
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT);

    apb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [NREQ-1:0] ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic          err_q, err_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            grant;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    apb_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Payload of the arbitration winner.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        grant       = 1'b0;

        case (state_q)
            StIdle: begin
                psel_d = 1'b0;
                grant  = arb_any;
            end
            StSetup: begin
                state_d   = StAccess;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StAccess: begin
                if (PREADY) begin
                    rsp_valid_d = NREQ'(1) << gidx_q;
                    err_d       = PSLVERR;
                    rdata_d     = pwrite_q ? '0 : PRDATA;
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                    grant       = arb_any;  // back-to-back keeps PSEL high
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Forced completion; always drops to IDLE, no re-arbitration.
                    rsp_valid_d = NREQ'(1) << gidx_q;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                end else begin
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                psel_d  = 1'b0;
            end
        endcase

        if (grant) begin
            state_d  = StSetup;
            psel_d   = 1'b1;
            pwrite_d = sel_write;
            paddr_d  = sel_addr;
            pwdata_d = sel_wdata;
            ready_d  = arb_gnt;
            gidx_d   = arb_idx;
            ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
        end
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed requests, a small APB slave memory
// with programmable wait states / error / stuck PREADY, and a response
// scoreboard checked by a monitor running alongside the stimulus.
module tb_apb_master_arbiter;

    logic        CLK, Rst;
    logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rsp_rdata, PWDATA, PRDATA;
    logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [4:0]  PADDR;

    apb_master_arbiter #(
        .NREQ    (4),
        .AW      (5),
        .DW      (8),
        .TIMEOUT (16)
    ) dut (
        .CLK       (CLK),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Slave model
    logic [7:0] mem [32];
    int wcnt = 0;
    int wait_n = 0;
    bit stuck = 1'b0;
    bit slverr = 1'b0;
    assign PREADY  = PSEL && PENABLE && !stuck && (wcnt >= wait_n);
    assign PRDATA  = mem[PADDR];
    assign PSLVERR = slverr && PREADY;
    always @(posedge CLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    logic [3:0] sticky = 4'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_rsp(int r, logic [7:0] rd, logic e, int lat);
        q.push_back('{r, rd, e, cyc + lat});
    endfunction

    task automatic issue(int r, bit w, logic [4:0] a, logic [7:0] d,
                         logic [7:0] rd, logic e, int lat);
        req_valid[r]         = 1'b1;
        req_write[r]         = w;
        req_addr[r*5 +: 5]   = a;
        req_wdata[r*8 +: 8]  = d;
        expect_rsp(r, rd, e, lat);
    endtask

    // Advance one cycle; requesters drop after their accept unless sticky.
    task automatic step();
        @(posedge CLK);
        #1;
        req_valid = req_valid & ~(req_ready & ~sticky);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) step();
        chk("drain_pending", q.size(), 0);
        step();
    endtask

    task automatic chk_zero(string name);
        chk(name, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid,
                   rsp_rdata, rsp_err}, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Rst = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;

        fork
            forever begin
                @(negedge CLK);
                if (rsp_valid != 4'b0) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", {28'h0, rsp_valid}, 32'h0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_onehot", {28'h0, rsp_valid}, 32'h1 << e.idx);
                        chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
                        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                        chk("rsp_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        #1 Rst = 1'b1;
        #10 chk_zero("reset_outputs");
        #1 Rst = 1'b0;
        step();

        // All four at once after reset: writes, granted 0,1,2,3 back-to-back.
        issue(0, 1'b1, 5'h03, 8'hA5, 8'h00, 1'b0, 3);
        issue(1, 1'b1, 5'h1F, 8'h3C, 8'h00, 1'b0, 5);
        issue(2, 1'b1, 5'h08, 8'h11, 8'h00, 1'b0, 7);
        issue(3, 1'b1, 5'h09, 8'h22, 8'h00, 1'b0, 9);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("b2b_psel", PSEL, 1);
            chk("b2b_ready", req_ready, (k % 2 == 0) ? (32'h1 << (k / 2)) : 32'h0);
        end
        step();
        chk("b2b_psel_drop", PSEL, 0);
        drain();

        // Single read with phase sequence.
        issue(0, 1'b0, 5'h03, 8'h00, 8'hA5, 1'b0, 3);
        step();
        chk("rd_setup", {PSEL, PENABLE, PWRITE}, 32'b100);
        chk("rd_ready", req_ready, 32'h1);
        chk("rd_paddr", PADDR, 32'h03);
        step();
        chk("rd_access", {PSEL, PENABLE}, 32'b11);
        chk("rd_ready_low", req_ready, 32'h0);
        step();
        chk("rd_idle", {PSEL, PENABLE}, 32'b00);
        drain();

        // Moves pointer to 0 so the next test starts with requester 0.
        issue(3, 1'b0, 5'h09, 8'h00, 8'h22, 1'b0, 3);
        drain();

        // Requesters 0 and 2 both keep requesting: grants alternate.
        sticky = 4'b0101;
        issue(0, 1'b0, 5'h03, 8'h00, 8'hA5, 1'b0, 3);
        issue(2, 1'b0, 5'h08, 8'h00, 8'h11, 1'b0, 5);
        expect_rsp(0, 8'hA5, 1'b0, 7);
        expect_rsp(2, 8'h11, 1'b0, 9);
        for (int k = 0; k < 7; k++) step();
        chk("alt_last_ready", req_ready, 32'h4);
        sticky = 4'b0;
        req_valid = '0;
        drain();

        // Three wait states plus slave error on a read.
        wait_n = 3;
        slverr = 1'b1;
        issue(0, 1'b0, 5'h1F, 8'h00, 8'h3C, 1'b1, 6);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("wait_paddr", PADDR, 32'h1F);
            chk("wait_psel", PSEL, 1);
        end
        step();
        chk("wait_psel_drop", PSEL, 0);
        drain();
        wait_n = 0;
        slverr = 1'b0;

        // PREADY stuck low: forced error after 16 ACCESS cycles.
        stuck = 1'b1;
        issue(1, 1'b0, 5'h07, 8'h00, 8'h00, 1'b1, 18);
        for (int k = 0; k < 17; k++) step();
        chk("to_still_busy", PSEL, 1);
        step();
        chk("to_idle", {PSEL, PENABLE}, 32'b00);
        drain();

        // Reset mid-ACCESS aborts the transfer and restarts priority at 0.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[5 +: 5] = 5'h10;
        req_wdata[8 +: 8] = 8'h55;
        step();
        step();
        chk("rst_in_access", {PSEL, PENABLE}, 32'b11);
        #2 Rst = 1'b1;
        #1 chk_zero("rst_async_outputs");
        req_valid = '0;
        #2 Rst = 1'b0;
        stuck = 1'b0;
        step();
        issue(0, 1'b0, 5'h03, 8'h00, 8'hA5, 1'b0, 3);
        issue(2, 1'b0, 5'h08, 8'h00, 8'h11, 1'b0, 5);
        drain();

        for (int k = 0; k < 4; k++) step();
        chk("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
